// File: rtl/color_scan_pkg.sv
// Shared constants and types for the colour sensor scan controller.
// Optional build macro: COLOR_SCAN_HYST_EN (colour ID hysteresis, see top).
package color_scan_pkg;

  // Photodiode filter select codes, driven as {S2,S3}
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // Published colour identifiers
  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  // Frequency scaling codes, driven as {S0,S1}
  localparam logic [1:0] SCALE_OFF = 2'b00;
  localparam logic [1:0] SCALE_20  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_GATE     = 2'd2,
    ST_CLASSIFY = 2'd3
  } state_t;

endpackage

// File: rtl/color_pulse_counter.sv
// Synchronises the asynchronous sensor output, detects rising edges and
// counts them into a saturating counter. The count output already includes
// an edge being accepted this cycle, so a snapshot taken on the last
// counting cycle does not lose the final edge.
module color_pulse_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             colorsignal,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_edge;
  logic [CNT_W-1:0] r_count;
  logic             w_inc;

  assign w_inc = count_en & r_edge & ~(&r_count);
  assign count = r_count + {{(CNT_W-1){1'b0}}, w_inc};

  // Two-flop synchroniser followed by a registered rising-edge pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= colorsignal;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  // Saturating edge counter; clear has priority over counting
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= count;
    end
  end

endmodule

// File: rtl/color_scan_ctrl.sv
// Colour sensor scan controller: steps the filter through red, blue, clear
// and green, counts sensor edges in a fixed gate window after a settle
// delay, then publishes the four counts plus a classified colour ID.
// Optional build macro: COLOR_SCAN_HYST_EN -- colour ID only changes after
// two consecutive scans agree on the new value.
//
// state       | meaning
// ST_IDLE     | sensor powered down, waiting for enable
// ST_SETTLE   | filter just changed, edges ignored
// ST_GATE     | counting edges for the current filter
// ST_CLASSIFY | one cycle, publish counts and colour ID on exit
module color_scan_ctrl
  import color_scan_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 100000,
  parameter int unsigned SETTLE_CYCLES = 10000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_CLEAR     = 50
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             colorsignal,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [1:0]       color_id,
  output logic             sample_valid,
  output logic             busy
);

  localparam int unsigned TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_filt, w_filt_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [1:0]       w_scale, w_filt_code;
  logic             w_count_en;
  logic [CNT_W-1:0] w_count;
  logic             w_timer_zero, w_gate_done, w_abort, w_classify;
  logic [1:0]       w_cls;

  logic [CNT_W-1:0] r_slot [4];
  logic [CNT_W-1:0] r_red_cnt, r_blue_cnt, r_clear_cnt, r_green_cnt;
  logic [1:0]       r_color;
  logic             r_valid;

  assign w_timer_zero = (r_timer == '0);
  assign w_gate_done  = (r_state == ST_GATE) && enable && w_timer_zero;
  assign w_abort      = ((r_state == ST_SETTLE) || (r_state == ST_GATE)) && !enable;
  assign w_classify   = (r_state == ST_CLASSIFY);

  color_pulse_counter #(.CNT_W(CNT_W)) u_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .colorsignal (colorsignal),
    .clear       (!w_count_en),
    .count_en    (w_count_en),
    .count       (w_count)
  );

  // FSM state, filter index and down-counting phase timer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_filt  <= FILT_RED;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_filt  <= w_filt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state: settle then gate for each filter, classify after green
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = r_filt;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_SETTLE;
          w_filt_nxt  = FILT_RED;
          w_timer_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timer_zero) begin
          w_state_nxt = ST_GATE;
          w_timer_nxt = GATE_LOAD;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timer_zero) begin
          if (r_filt == FILT_GREEN) begin
            w_state_nxt = ST_CLASSIFY;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_filt_nxt  = r_filt + 2'd1;
            w_timer_nxt = SETTLE_LOAD;
          end
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_CLASSIFY: begin
        if (enable) begin
          w_state_nxt = ST_SETTLE;
          w_filt_nxt  = FILT_RED;
          w_timer_nxt = SETTLE_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sensor control outputs and counter gating decoded from state
  always_comb begin
    w_scale     = SCALE_OFF;
    w_filt_code = FILT_RED;
    busy        = 1'b0;
    w_count_en  = 1'b0;
    if (r_state != ST_IDLE) begin
      w_scale     = SCALE_20;
      w_filt_code = r_filt;
      busy        = 1'b1;
    end
    if (r_state == ST_GATE) begin
      w_count_en = 1'b1;
    end
  end

  assign {S0, S1} = w_scale;
  assign {S2, S3} = w_filt_code;

  // Classify from the slot snapshots; ties resolve red, then green, then blue
  always_comb begin
    w_cls = COL_NONE;
    if (32'(r_slot[FILT_CLEAR]) >= MIN_CLEAR) begin
      if ((r_slot[FILT_RED] >= r_slot[FILT_GREEN]) && (r_slot[FILT_RED] >= r_slot[FILT_BLUE])) begin
        w_cls = COL_RED;
      end else if (r_slot[FILT_GREEN] >= r_slot[FILT_BLUE]) begin
        w_cls = COL_GREEN;
      end else begin
        w_cls = COL_BLUE;
      end
    end
  end

  // Per-filter slots, published counts and the one-cycle valid pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
      r_red_cnt   <= '0;
      r_blue_cnt  <= '0;
      r_clear_cnt <= '0;
      r_green_cnt <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_classify;
      if (w_gate_done) r_slot[r_filt] <= w_count;
      if (w_classify) begin
        r_red_cnt   <= r_slot[FILT_RED];
        r_blue_cnt  <= r_slot[FILT_BLUE];
        r_clear_cnt <= r_slot[FILT_CLEAR];
        r_green_cnt <= r_slot[FILT_GREEN];
      end
    end
  end

`ifdef COLOR_SCAN_HYST_EN
  logic [1:0] r_cand;
  logic       r_cand_vld;

  // Colour ID moves only when two consecutive classifications agree
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_color    <= COL_NONE;
      r_cand     <= COL_NONE;
      r_cand_vld <= 1'b0;
    end else if (w_abort) begin
      r_cand_vld <= 1'b0;
    end else if (w_classify) begin
      if (w_cls == r_color) begin
        r_cand_vld <= 1'b0;
      end else if (r_cand_vld && (r_cand == w_cls)) begin
        r_color    <= w_cls;
        r_cand_vld <= 1'b0;
      end else begin
        r_cand     <= w_cls;
        r_cand_vld <= 1'b1;
      end
    end
  end
`else
  // Colour ID follows every classification
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_color <= COL_NONE;
    end else if (w_classify) begin
      r_color <= w_cls;
    end
  end
`endif

  assign red_cnt      = r_red_cnt;
  assign blue_cnt     = r_blue_cnt;
  assign clear_cnt    = r_clear_cnt;
  assign green_cnt    = r_green_cnt;
  assign color_id     = r_color;
  assign sample_valid = r_valid;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// Bench for color_scan_ctrl: a 16-bit and a 4-bit counter build share the
// same stimulus; expected counts and colour IDs come from a scan-level model.
module tb_color_scan_ctrl;

  localparam int G  = 100;
  localparam int S  = 10;
  localparam int MC = 5;

  logic clock = 1'b0;
  logic reset_n, enable, colorsignal;

  logic        s0_a, s1_a, s2_a, s3_a, valid_a, busy_a;
  logic [15:0] red_a, blue_a, clear_a, green_a;
  logic [1:0]  id_a;
  logic        s0_b, s1_b, s2_b, s3_b, valid_b, busy_b;
  logic [3:0]  red_b, blue_b, clear_b, green_b;
  logic [1:0]  id_b;

  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16), .MIN_CLEAR(MC)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .colorsignal(colorsignal),
    .S0(s0_a), .S1(s1_a), .S2(s2_a), .S3(s3_a),
    .red_cnt(red_a), .blue_cnt(blue_a), .clear_cnt(clear_a), .green_cnt(green_a),
    .color_id(id_a), .sample_valid(valid_a), .busy(busy_a));

  color_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .MIN_CLEAR(MC)) dut_sat (
    .clock(clock), .reset_n(reset_n), .enable(enable), .colorsignal(colorsignal),
    .S0(s0_b), .S1(s1_b), .S2(s2_b), .S3(s3_b),
    .red_cnt(red_b), .blue_cnt(blue_b), .clear_cnt(clear_b), .green_cnt(green_b),
    .color_id(id_b), .sample_valid(valid_b), .busy(busy_b));

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model state, index [k][filter]: k=0 16-bit build, k=1 4-bit build;
  // filter 0 red, 1 blue, 2 clear, 3 green.
  int         exp_cnt [2][4];
  logic [1:0] exp_id  [2];
  logic [1:0] prev_cls[2];
  bit         prev_vld[2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] ref_classify(input int r, input int g, input int b, input int c);
    int best;
    if (c < MC) return 2'd0;
    best = r;
    if (g > best) best = g;
    if (b > best) best = b;
    if (r == best) return 2'd1;
    if (g == best) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 4; f++) exp_cnt[k][f] = 0;
      exp_id[k]   = 2'd0;
      prev_cls[k] = 2'd0;
      prev_vld[k] = 1'b0;
    end
  endtask

  task automatic model_publish(input int nr, input int nb, input int nc, input int ng);
    int lim;
    logic [1:0] cls;
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 65535 : 15;
      exp_cnt[k][0] = (nr > lim) ? lim : nr;
      exp_cnt[k][1] = (nb > lim) ? lim : nb;
      exp_cnt[k][2] = (nc > lim) ? lim : nc;
      exp_cnt[k][3] = (ng > lim) ? lim : ng;
      cls = ref_classify(exp_cnt[k][0], exp_cnt[k][3], exp_cnt[k][1], exp_cnt[k][2]);
`ifdef COLOR_SCAN_HYST_EN
      if (cls != exp_id[k] && prev_vld[k] && prev_cls[k] == cls) exp_id[k] = cls;
      prev_cls[k] = cls;
      prev_vld[k] = 1'b1;
`else
      exp_id[k] = cls;
`endif
    end
  endtask

  task automatic chk_pub(input string tag);
    chk({tag, " red_a"},   32'(red_a),   exp_cnt[0][0]);
    chk({tag, " blue_a"},  32'(blue_a),  exp_cnt[0][1]);
    chk({tag, " clear_a"}, 32'(clear_a), exp_cnt[0][2]);
    chk({tag, " green_a"}, 32'(green_a), exp_cnt[0][3]);
    chk({tag, " id_a"},    32'(id_a),    32'(exp_id[0]));
    chk({tag, " red_b"},   32'(red_b),   exp_cnt[1][0]);
    chk({tag, " blue_b"},  32'(blue_b),  exp_cnt[1][1]);
    chk({tag, " clear_b"}, 32'(clear_b), exp_cnt[1][2]);
    chk({tag, " green_b"}, 32'(green_b), exp_cnt[1][3]);
    chk({tag, " id_b"},    32'(id_b),    32'(exp_id[1]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy_a"},  32'(busy_a), 0);
    chk({tag, " busy_b"},  32'(busy_b), 0);
    chk({tag, " s_a"},     32'({s0_a, s1_a, s2_a, s3_a}), 0);
    chk({tag, " s_b"},     32'({s0_b, s1_b, s2_b, s3_b}), 0);
    chk({tag, " valid_a"}, 32'(valid_a), 0);
    chk({tag, " valid_b"}, 32'(valid_b), 0);
  endtask

  // One filter: settle (with edges that must be ignored) then gate_len gate
  // cycles with n edges placed well inside the window.
  task automatic phase(input int f, input int n, input int gate_len);
    chk("busy", 32'(busy_a), 1);
    chk("scale", 32'({s0_a, s1_a}), 32'h2);
    chk("filter_a", 32'({s2_a, s3_a}), 32'(f));
    chk("filter_b", 32'({s2_b, s3_b}), 32'(f));
    for (int j = 0; j < S; j++) begin
      colorsignal = (j == 1) || (j == 3);
      tick();
      if (f == 0 && j == 0) chk("valid_width", 32'(valid_a), 0);
    end
    for (int j = 0; j < gate_len; j++) begin
      if (j == 0) chk("valid_gate", 32'(valid_a | valid_b), 0);
      colorsignal = (j >= 2) && (j < 2 + 2 * n) && (j % 2 == 0);
      tick();
    end
    colorsignal = 1'b0;
  endtask

  task automatic run_scan(input int nr, input int nb, input int nc, input int ng,
                          input bit from_idle, input bit stay_on);
    int n[4];
    n = '{nr, nb, nc, ng};
    if (from_idle) begin
      enable = 1'b1;
      tick();
    end
    for (int f = 0; f < 4; f++) phase(f, n[f], G);
    // CLASSIFY cycle: nothing published yet
    chk("pre_valid", 32'(valid_a | valid_b), 0);
    chk_pub("pre");
    enable = stay_on;
    tick();
    model_publish(nr, nb, nc, ng);
    chk("valid_a", 32'(valid_a), 1);
    chk("valid_b", 32'(valid_b), 1);
    chk_pub("scan");
    chk("busy_after", 32'(busy_a), 32'(stay_on));
    if (!stay_on) begin
      tick();
      chk_idle("post");
    end
  endtask

  task automatic run_abort();
    enable = 1'b1;
    tick();
    phase(0, 25, G);
    phase(1, 7, G);
    phase(2, 15, 50);
    enable = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) prev_vld[k] = 1'b0;
    chk_idle("abort");
    chk_pub("abort");
    repeat (3) tick();
    chk_idle("abort_late");
  endtask

  task automatic run_reset_mid();
    enable = 1'b1;
    tick();
    phase(0, 10, 30);
    reset_n = 1'b0;
    enable  = 1'b0;
    tick();
    model_reset();
    chk_idle("midrst");
    chk_pub("midrst");
    reset_n = 1'b1;
    tick();
    chk_idle("midrst_rel");
  endtask

  initial begin
    bit cont;
    bit stay;
    int nr, nb, nc, ng;
    reset_n = 1'b0;
    enable = 1'b1;
    colorsignal = 1'b0;
    model_reset();
    repeat (5) begin
      tick();
      chk_idle("reset");
      chk_pub("reset");
    end
    reset_n = 1'b1;
    enable  = 1'b0;
    tick();
    chk_idle("idle");

    run_scan(20, 8, 30, 10, 1'b1, 1'b0);   // red
    run_scan(9, 2, 3, 4, 1'b1, 1'b0);      // dark
    run_scan(12, 5, 40, 12, 1'b1, 1'b1);   // red/green tie
    run_scan(4, 12, 40, 12, 1'b0, 1'b0);   // green/blue tie, continuous
    run_scan(20, 3, 30, 10, 1'b1, 1'b0);   // red saturates in 4-bit build
    run_scan(2, 20, 30, 5, 1'b1, 1'b0);    // blue
    run_scan(3, 18, 25, 6, 1'b1, 1'b0);    // blue again

    cont = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nr = $urandom_range(0, 40);
      nb = $urandom_range(0, 40);
      ng = $urandom_range(0, 40);
      nc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 40);
      stay = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      run_scan(nr, nb, nc, ng, !cont, stay);
      cont = stay;
    end

    run_abort();
    run_scan(6, 30, 35, 11, 1'b1, 1'b0);
    run_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
